// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the sequence-implication monitor and its attempt slots.
package seq_mon_pkg;

  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_VACUOUS} verdict_e;

  typedef enum logic [1:0] {S_IDLE, S_ANT, S_CON_IMPL, S_WAIT_IMPLIES} slot_state_e;

  // An attempt lives ANT_LEN+CON_LEN-1 edges and starts are >=2 edges apart.
  function automatic int num_slots(input int ant_len, input int con_len);
    return (ant_len + con_len) / 2;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/seq_attempt_slot.sv
// Tracks one attempt of $rose(a) ##0 a[*ANT_LEN] against b[*CON_LEN] for both |-> and implies.
module seq_attempt_slot
  import seq_mon_pkg::*;
#(
  parameter int ANT_LEN = 2,
  parameter int CON_LEN = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_start,
  input  logic     i_a,
  input  logic     i_b,
  output logic     o_busy,
  output verdict_e o_impl_v,
  output verdict_e o_implies_v
);

  localparam int KW = $clog2(ANT_LEN + CON_LEN + 1);
  localparam logic [KW-1:0] K_ANT_END = KW'(ANT_LEN - 1);
  localparam logic [KW-1:0] K_CON_LEN = KW'(CON_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(ANT_LEN + CON_LEN - 2);
  localparam logic [KW-1:0] K_IMP_LAST = KW'(((ANT_LEN > CON_LEN) ? ANT_LEN : CON_LEN) - 1);

  slot_state_e   r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt, w_k;
  logic          r_bfail, w_bfail_nxt, w_bfail;
  logic          w_in_ant, w_matched, w_imp_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_bfail <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_bfail <= w_bfail_nxt;
    end
  end

  // The start edge itself is evaluated here, so a fresh attempt sees k=0 with clean flags.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_bfail_nxt   = r_bfail;
    o_impl_v      = V_NONE;
    o_implies_v   = V_NONE;
    w_k           = i_start ? '0 : r_k;
    w_in_ant      = i_start || (r_state == S_ANT);
    w_bfail       = (!i_start && r_bfail) || ((w_k < K_CON_LEN) && !i_b);
    w_matched     = 1'b0;
    w_imp_pending = w_in_ant || (r_state == S_WAIT_IMPLIES);

    if (i_start || (r_state != S_IDLE)) begin
      if (w_in_ant && !i_a) begin
        o_impl_v    = V_VACUOUS;
        o_implies_v = V_VACUOUS;
        w_state_nxt = S_IDLE;
      end else begin
        w_matched = !w_in_ant || (w_k == K_ANT_END);
        if (w_matched) begin
          if (!i_b)                o_impl_v = V_FAIL;
          else if (w_k == K_LAST)  o_impl_v = V_PASS;
          if (w_imp_pending) begin
            if (w_bfail)                 o_implies_v = V_FAIL;
            else if (w_k == K_IMP_LAST)  o_implies_v = V_PASS;
          end
        end
        w_k_nxt     = w_k + KW'(1);
        w_bfail_nxt = w_bfail;
        // implies always decides no later than |->, so a |-> verdict frees the slot.
        if (o_impl_v != V_NONE)
          w_state_nxt = S_IDLE;
        else if (!w_matched)
          w_state_nxt = S_ANT;
        else if (w_imp_pending && (o_implies_v == V_NONE))
          w_state_nxt = S_WAIT_IMPLIES;
        else
          w_state_nxt = S_CON_IMPL;
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: rtl/seq_implies_monitor.sv
// Synthesizable checker evaluating |-> and implies for $rose(a) ##0 a[*ANT_LEN] vs b[*CON_LEN].
module seq_implies_monitor
  import seq_mon_pkg::*;
#(
  parameter int ANT_LEN = 2,
  parameter int CON_LEN = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             impl_pass,
  output logic             impl_fail,
  output logic             implies_pass,
  output logic             implies_fail,
  output logic [CNT_W-1:0] impl_pass_cnt,
  output logic [CNT_W-1:0] impl_fail_cnt,
  output logic [CNT_W-1:0] implies_pass_cnt,
  output logic [CNT_W-1:0] implies_fail_cnt
);

  localparam int NUM_SLOTS = num_slots(ANT_LEN, CON_LEN);
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << CNT_W) - 64'd1);
  // Verdict kinds, in counter/pulse index order.
  localparam int K_IMPL_PASS = 0, K_IMPL_FAIL = 1, K_IMPLIES_PASS = 2, K_IMPLIES_FAIL = 3;

  logic                 r_a_prev;
  logic                 w_rose;
  logic [NUM_SLOTS-1:0] w_start, w_busy;
  verdict_e             w_impl_v    [NUM_SLOTS];
  verdict_e             w_implies_v [NUM_SLOTS];
  logic [31:0]          w_inc       [4];
  logic [31:0]          w_cnt_nxt   [4];
  logic [3:0]           r_pulse;
  logic [CNT_W-1:0]     r_cnt       [4];

  assign w_rose = a && !r_a_prev;

  always_comb begin
    logic found;
    found   = 1'b0;
    w_start = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_rose && !found && !w_busy[s]) begin
        w_start[s] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    seq_attempt_slot #(.ANT_LEN(ANT_LEN), .CON_LEN(CON_LEN)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start[g]),
      .i_a        (a),
      .i_b        (b),
      .o_busy     (w_busy[g]),
      .o_impl_v   (w_impl_v[g]),
      .o_implies_v(w_implies_v[g])
    );
  end

  // Several slots can reach the same verdict on one edge; the counters add all of them.
  always_comb begin
    for (int i = 0; i < 4; i++) w_inc[i] = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_impl_v[s] == V_PASS)    w_inc[K_IMPL_PASS]    = w_inc[K_IMPL_PASS] + 32'd1;
      if (w_impl_v[s] == V_FAIL)    w_inc[K_IMPL_FAIL]    = w_inc[K_IMPL_FAIL] + 32'd1;
      if (w_implies_v[s] == V_PASS) w_inc[K_IMPLIES_PASS] = w_inc[K_IMPLIES_PASS] + 32'd1;
      if (w_implies_v[s] == V_FAIL) w_inc[K_IMPLIES_FAIL] = w_inc[K_IMPLIES_FAIL] + 32'd1;
    end
    for (int i = 0; i < 4; i++) w_cnt_nxt[i] = sat_add(32'(r_cnt[i]), w_inc[i], CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_prev <= 1'b0;
      r_pulse  <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is intended.
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_a_prev <= a;
      for (int i = 0; i < 4; i++) begin
        r_pulse[i] <= (w_inc[i] != 32'd0);
        r_cnt[i]   <= w_cnt_nxt[i][CNT_W-1:0];
      end
    end
  end

  assign impl_pass        = r_pulse[K_IMPL_PASS];
  assign impl_fail        = r_pulse[K_IMPL_FAIL];
  assign implies_pass     = r_pulse[K_IMPLIES_PASS];
  assign implies_fail     = r_pulse[K_IMPLIES_FAIL];
  assign impl_pass_cnt    = r_cnt[K_IMPL_PASS];
  assign impl_fail_cnt    = r_cnt[K_IMPL_FAIL];
  assign implies_pass_cnt = r_cnt[K_IMPLIES_PASS];
  assign implies_fail_cnt = r_cnt[K_IMPLIES_FAIL];

endmodule
